// File: rtl/uart_mm_fifo.sv
// Memory-mapped 8N1 UART with TX/RX byte FIFOs, runtime baud divisor,
// sticky error flags and a registered level interrupt. Four-word window at BASE.
module uart_mm_fifo #(
   parameter logic [31:0] BASE        = 32'd65537,
   parameter int          DEPTH_LOG2  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   input  logic [31:0] addr_b,
   input  logic [31:0] data_b_in,
   input  logic [31:0] data_b_we,
   output logic [31:0] data_b,
   output logic        strobe_b,
   output logic        irq
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [31:0] r_prev_addr;
   logic        r_prev_we;
   logic [15:0] r_div;
   logic [1:0]  r_ien;
   logic        r_ovr, r_ferr, r_txdrop, r_irq;
   logic [31:0] r_data;
   logic        r_strobe;

   logic [7:0]            r_tx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_tx_wp, r_tx_rp;
   logic [CW-1:0]         r_tx_cnt;
   logic [7:0]            r_rx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_rx_wp, r_rx_rp;
   logic [CW-1:0]         r_rx_cnt;

   logic [1:0]  r_tx_st;
   logic [15:0] r_tx_div, r_tx_ccnt;
   logic [2:0]  r_tx_bit;
   logic [7:0]  r_tx_sh;
   logic        r_tx_o;

   logic        r_rx_s1, r_rx_s2, r_rx_s3;
   logic [1:0]  r_rx_st;
   logic [15:0] r_rx_div, r_rx_ccnt;
   logic [2:0]  r_rx_bit;
   logic [7:0]  r_rx_sh;

   logic [31:0]   w_off, w_status, w_rdata;
   logic          w_win, w_wr, w_rd, w_rd_first, w_stat_wr;
   logic          w_tx_full, w_tx_empty, w_tx_push, w_tx_push_ok, w_tx_pop, w_tx_tick;
   logic          w_rx_full, w_rx_empty, w_rx_push, w_rx_push_ok, w_rx_pop, w_rx_tick, w_rx_done;
   logic [CW-1:0] w_tx_cnt_nxt, w_rx_cnt_nxt;
   logic          w_unused;

   // Window test by offset so BASE near the top of the address space still works.
   assign w_off      = addr_b - BASE;
   assign w_win      = (w_off[31:2] == 30'd0);
   assign w_wr       = w_win & data_b_we[0];
   assign w_rd       = w_win & ~data_b_we[0];
   assign w_rd_first = w_rd & ((addr_b != r_prev_addr) | r_prev_we);
   assign w_stat_wr  = w_wr & (w_off[1:0] == 2'd1);
   assign w_unused   = ^{data_b_we[31:1], data_b_in[31:16]};

   assign w_tx_full    = (r_tx_cnt == FULL);
   assign w_tx_empty   = (r_tx_cnt == '0);
   assign w_tx_push    = w_wr & (w_off[1:0] == 2'd0);
   assign w_tx_push_ok = w_tx_push & ~w_tx_full;
   assign w_tx_pop     = (r_tx_st == S_IDLE) & ~w_tx_empty;
   assign w_tx_cnt_nxt = r_tx_cnt + CW'(w_tx_push_ok) - CW'(w_tx_pop);

   assign w_rx_full    = (r_rx_cnt == FULL);
   assign w_rx_empty   = (r_rx_cnt == '0);
   assign w_rx_done    = (r_rx_st == S_STOP) & w_rx_tick;
   assign w_rx_push    = w_rx_done & r_rx_s2;
   assign w_rx_push_ok = w_rx_push & ~w_rx_full;
   assign w_rx_pop     = w_rd_first & (w_off[1:0] == 2'd0) & ~w_rx_empty;
   assign w_rx_cnt_nxt = r_rx_cnt + CW'(w_rx_push_ok) - CW'(w_rx_pop);

   assign w_tx_tick = (r_tx_ccnt == r_tx_div - 16'd1);
   assign w_rx_tick = (r_rx_st == S_START) ? (r_rx_ccnt == ({1'b0, r_rx_div[15:1]} - 16'd1))
                                           : (r_rx_ccnt == r_rx_div - 16'd1);

   assign w_status = {8'd0, 8'(r_tx_cnt), 8'(r_rx_cnt), 2'b00, r_txdrop, r_ferr, r_ovr,
                      w_tx_empty & (r_tx_st == S_IDLE), ~w_tx_full, ~w_rx_empty};

   always_comb begin
      w_rdata = 32'd0;
      case (w_off[1:0])
         2'd0:    w_rdata = w_rx_empty ? 32'd0 : {24'd0, r_rx_mem[r_rx_rp]};
         2'd1:    w_rdata = w_status;
         2'd2:    w_rdata = {16'd0, r_div};
         default: w_rdata = {30'd0, r_ien};
      endcase
   end

   // Bus side: registers, sticky flags, read data, interrupt.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev_addr <= 32'd0;
         r_prev_we   <= 1'b1;
         r_div       <= DEFAULT_DIV;
         r_ien       <= 2'b00;
         r_ovr       <= 1'b0;
         r_ferr      <= 1'b0;
         r_txdrop    <= 1'b0;
         r_data      <= 32'd0;
         r_strobe    <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         r_prev_addr <= addr_b;
         r_prev_we   <= data_b_we[0];
         if (w_wr && w_off[1:0] == 2'd2)
            r_div <= (data_b_in[15:0] < 16'd4) ? 16'd4 : data_b_in[15:0];
         if (w_wr && w_off[1:0] == 2'd3)
            r_ien <= data_b_in[1:0];
         // A new error in the same cycle as a clear wins.
         r_ovr    <= (w_rx_push & w_rx_full) | (r_ovr & ~(w_stat_wr & data_b_in[3]));
         r_ferr   <= (w_rx_done & ~r_rx_s2) | (r_ferr & ~(w_stat_wr & data_b_in[4]));
         r_txdrop <= (w_tx_push & w_tx_full) | (r_txdrop & ~(w_stat_wr & data_b_in[5]));
         r_strobe <= w_rd;
         if (!w_rd)
            r_data <= 32'd0;
         else if (w_rd_first || w_off[1:0] != 2'd0)
            r_data <= w_rdata;
         r_irq <= (r_ien[0] & (w_rx_cnt_nxt != '0)) | (r_ien[1] & (w_tx_cnt_nxt == '0));
      end
   end

   always_ff @(posedge clk) begin
      if (w_tx_push_ok) r_tx_mem[r_tx_wp] <= data_b_in[7:0];
      if (w_rx_push_ok) r_rx_mem[r_rx_wp] <= r_rx_sh;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_tx_push_ok) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_pop)     r_tx_rp <= r_tx_rp + 1'b1;
         if (w_rx_push_ok) r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop)     r_rx_rp <= r_rx_rp + 1'b1;
         r_tx_cnt <= w_tx_cnt_nxt;
         r_rx_cnt <= w_rx_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_st   <= S_IDLE;
         r_tx_div  <= DEFAULT_DIV;
         r_tx_ccnt <= 16'd0;
         r_tx_bit  <= 3'd0;
         r_tx_sh   <= 8'd0;
         r_tx_o    <= 1'b1;
      end else begin
         case (r_tx_st)
            S_IDLE: if (!w_tx_empty) begin
               r_tx_st   <= S_START;
               r_tx_o    <= 1'b0;
               r_tx_sh   <= r_tx_mem[r_tx_rp];
               r_tx_div  <= r_div;
               r_tx_ccnt <= 16'd0;
            end
            S_START: if (w_tx_tick) begin
               r_tx_st   <= S_DATA;
               r_tx_o    <= r_tx_sh[0];
               r_tx_bit  <= 3'd0;
               r_tx_ccnt <= 16'd0;
            end else r_tx_ccnt <= r_tx_ccnt + 16'd1;
            S_DATA: if (w_tx_tick) begin
               r_tx_ccnt <= 16'd0;
               if (r_tx_bit == 3'd7) begin
                  r_tx_st <= S_STOP;
                  r_tx_o  <= 1'b1;
               end else begin
                  r_tx_bit <= r_tx_bit + 3'd1;
                  r_tx_o   <= r_tx_sh[1];
                  r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
               end
            end else r_tx_ccnt <= r_tx_ccnt + 16'd1;
            default: if (w_tx_tick) r_tx_st <= S_IDLE;
                     else r_tx_ccnt <= r_tx_ccnt + 16'd1;
         endcase
      end
   end

   // RX: first sample lands mid start bit, then one sample per bit period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_s3   <= 1'b1;
         r_rx_st   <= S_IDLE;
         r_rx_div  <= DEFAULT_DIV;
         r_rx_ccnt <= 16'd0;
         r_rx_bit  <= 3'd0;
         r_rx_sh   <= 8'd0;
      end else begin
         r_rx_s1 <= RX;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
         case (r_rx_st)
            S_IDLE: if (r_rx_s3 && !r_rx_s2) begin
               r_rx_st   <= S_START;
               r_rx_div  <= r_div;
               r_rx_ccnt <= 16'd0;
            end
            S_START: if (w_rx_tick) begin
               r_rx_st   <= r_rx_s2 ? S_IDLE : S_DATA;
               r_rx_bit  <= 3'd0;
               r_rx_ccnt <= 16'd0;
            end else r_rx_ccnt <= r_rx_ccnt + 16'd1;
            S_DATA: if (w_rx_tick) begin
               r_rx_sh   <= {r_rx_s2, r_rx_sh[7:1]};
               r_rx_ccnt <= 16'd0;
               if (r_rx_bit == 3'd7) r_rx_st <= S_STOP;
               else                  r_rx_bit <= r_rx_bit + 3'd1;
            end else r_rx_ccnt <= r_rx_ccnt + 16'd1;
            default: if (w_rx_tick) r_rx_st <= S_IDLE;
                     else r_rx_ccnt <= r_rx_ccnt + 16'd1;
         endcase
      end
   end

   assign TX       = r_tx_o;
   assign data_b   = r_data;
   assign strobe_b = r_strobe;
   assign irq      = r_irq;
endmodule

// File: tb/tb_uart_mm_fifo.sv
// Directed bench for uart_mm_fifo: register table plus TX/RX/FIFO/irq/reset sequences.
module tb_uart_mm_fifo;
   localparam logic [31:0] BASE = 32'd65537;

   logic        clk = 1'b0, rst = 1'b0, rx_drv = 1'b1, loopb = 1'b0;
   logic        TX, rx_line, strobe_b, irq;
   logic [31:0] addr_b = 32'd0, data_b_in = 32'd0, data_b_we = 32'd0, data_b;
   int          n_vec = 0, n_bad = 0;

   assign rx_line = loopb ? TX : rx_drv;
   always #5 clk = ~clk;

   uart_mm_fifo #(.BASE(BASE), .DEPTH_LOG2(2), .DEFAULT_DIV(16'd868)) dut (
      .clk(clk), .rst(rst), .RX(rx_line), .TX(TX), .addr_b(addr_b), .data_b_in(data_b_in),
      .data_b_we(data_b_we), .data_b(data_b), .strobe_b(strobe_b), .irq(irq));

   typedef struct {
      logic [31:0] off;
      logic        we;
      logic [31:0] wd;
      logic        exp_s;
      logic [31:0] exp_d;
   } vec_t;
   vec_t tbl [15];

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic bus_idle();
      addr_b = 32'd0; data_b_we = 32'd0; data_b_in = 32'd0;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      addr_b = BASE + off; data_b_in = d; data_b_we = 32'd1;
      cyc(); bus_idle(); cyc();
   endtask

   task automatic rd(input logic [31:0] off, output logic [31:0] d, output logic s);
      addr_b = BASE + off; data_b_we = 32'd0;
      cyc(); d = data_b; s = strobe_b;
      bus_idle(); cyc();
   endtask

   task automatic rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
      logic [31:0] d;
      logic        s;
      rd(off, d, s);
      check(name, 64'({s, d}), 64'({1'b1, exp}));
   endtask

   task automatic wait_stat(input string name, input logic [31:0] mask);
      logic [31:0] d;
      logic        s;
      logic        ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         rd(32'd1, d, s);
         ok = ((d & mask) == mask);
      end
      check(name, 64'(ok), 64'(1'b1));
   endtask

   // RX frame at divisor 4: start, 8 data LSB first, stop, then line idle.
   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = fr[i];
         repeat (4) cyc();
      end
      rx_drv = 1'b1;
      repeat (6) cyc();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] got, expv;
      logic [9:0]  fr;
      logic [7:0]  rxb [4];
      int          w;

      tbl[0]  = '{32'd1,          1'b0, 32'd0,          1'b1, 32'h0000_0006};
      tbl[1]  = '{32'd2,          1'b0, 32'd0,          1'b1, 32'd868};
      tbl[2]  = '{32'd3,          1'b0, 32'd0,          1'b1, 32'd0};
      tbl[3]  = '{32'd0,          1'b0, 32'd0,          1'b1, 32'd0};
      tbl[4]  = '{32'd4,          1'b0, 32'd0,          1'b0, 32'd0};
      tbl[5]  = '{32'hFFFF_FFFF,  1'b0, 32'd0,          1'b0, 32'd0};
      tbl[6]  = '{32'd2,          1'b1, 32'd2,          1'b0, 32'd0};
      tbl[7]  = '{32'd2,          1'b0, 32'd0,          1'b1, 32'd4};
      tbl[8]  = '{32'd2,          1'b1, 32'h0001_1234,  1'b0, 32'd0};
      tbl[9]  = '{32'd2,          1'b0, 32'd0,          1'b1, 32'h0000_1234};
      tbl[10] = '{32'd3,          1'b1, 32'hFF,         1'b0, 32'd0};
      tbl[11] = '{32'd3,          1'b0, 32'd0,          1'b1, 32'd3};
      tbl[12] = '{32'd3,          1'b1, 32'd0,          1'b0, 32'd0};
      tbl[13] = '{32'd2,          1'b1, 32'd4,          1'b0, 32'd0};
      tbl[14] = '{32'd2,          1'b0, 32'd0,          1'b1, 32'd4};

      repeat (3) cyc();
      check("reset_outputs", 64'({TX, strobe_b, irq, data_b}), 64'({1'b1, 1'b0, 1'b0, 32'd0}));
      rst = 1'b1;
      cyc();

      for (int i = 0; i < 15; i++) begin
         addr_b = BASE + tbl[i].off; data_b_we = {31'd0, tbl[i].we}; data_b_in = tbl[i].wd;
         cyc();
         check($sformatf("vec%0d", i), 64'({strobe_b, data_b}), 64'({tbl[i].exp_s, tbl[i].exp_d}));
         bus_idle(); cyc();
      end

      // TX frame of 0x55 at divisor 4.
      addr_b = BASE; data_b_in = 32'h55; data_b_we = 32'd1;
      cyc(); bus_idle();
      check("tx_not_early", 64'(TX), 64'(1'b1));
      w = 0;
      while (w < 20 && TX !== 1'b0) begin cyc(); w++; end
      check("tx_start_seen", 64'(TX), 64'(1'b0));
      fr = {1'b1, 8'h55, 1'b0};
      for (int k = 0; k < 40; k++) begin
         expv[k] = fr[k / 4];
         got[k]  = TX;
         cyc();
      end
      check("tx_frame_55", 64'(got), 64'(expv));
      check("tx_idle_line", 64'(TX), 64'(1'b1));
      rd_chk("tx_idle_status", 32'd1, 32'h0000_0006);

      // TX FIFO overflow with the shifter busy.
      wr(32'd0, 32'h00);
      repeat (3) cyc();
      addr_b = BASE; data_b_we = 32'd1;
      for (int i = 0; i < 5; i++) begin data_b_in = 32'h30 + i; cyc(); end
      bus_idle(); cyc();
      rd_chk("txdrop_set", 32'd1, 32'h0004_0020);
      wr(32'd1, 32'h20);
      rd_chk("txdrop_clr", 32'd1, 32'h0004_0000);
      wait_stat("tx_drain_wait", 32'h4);

      // Loopback byte, held DATA read pops once.
      loopb = 1'b1;
      wr(32'd0, 32'hA3);
      wait_stat("rxne_wait", 32'h1);
      addr_b = BASE; data_b_we = 32'd0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check($sformatf("held_read%0d", i), 64'({strobe_b, data_b}), 64'({1'b1, 32'hA3}));
      end
      bus_idle(); cyc();
      rd_chk("read_empty", 32'd0, 32'd0);
      rd_chk("status_after_pop", 32'd1, 32'h0000_0006);
      loopb = 1'b0;
      cyc();

      // Framing error.
      send_rx(8'h3C, 1'b0);
      rd_chk("ferr_set", 32'd1, 32'h0000_0016);
      wr(32'd1, 32'h10);
      rd_chk("ferr_clr", 32'd1, 32'h0000_0006);

      // RX overrun.
      rxb = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) send_rx(rxb[i], 1'b1);
      send_rx(8'h55, 1'b1);
      rd_chk("ovr_set", 32'd1, 32'h0000_040F);
      for (int i = 0; i < 4; i++) rd_chk($sformatf("rx_byte%0d", i), 32'd0, {24'd0, rxb[i]});
      wr(32'd1, 32'h08);
      rd_chk("ovr_clr", 32'd1, 32'h0000_0006);

      // Interrupt.
      wr(32'd3, 32'd1);
      cyc();
      check("irq_rx_empty", 64'(irq), 64'(1'b0));
      send_rx(8'h5A, 1'b1);
      check("irq_rx_byte", 64'(irq), 64'(1'b1));
      addr_b = BASE; data_b_we = 32'd0;
      cyc();
      check("irq_pop_data", 64'({strobe_b, data_b}), 64'({1'b1, 32'h5A}));
      check("irq_after_pop", 64'(irq), 64'(1'b0));
      bus_idle(); cyc();
      wr(32'd3, 32'd2);
      check("irq_tx_empty", 64'(irq), 64'(1'b1));
      wr(32'd3, 32'd0);
      cyc();
      check("irq_disabled", 64'(irq), 64'(1'b0));

      // Reset in the middle of a TX frame.
      wr(32'd0, 32'h00);
      wr(32'd0, 32'hFF);
      repeat (4) cyc();
      check("tx_busy_low", 64'(TX), 64'(1'b0));
      #2 rst = 1'b0;
      #1 check("tx_async_reset", 64'(TX), 64'(1'b1));
      repeat (2) cyc();
      rst = 1'b1;
      cyc();
      rd_chk("status_post_reset", 32'd1, 32'h0000_0006);
      rd_chk("div_post_reset", 32'd2, 32'd868);
      rd_chk("ien_post_reset", 32'd3, 32'd0);
      check("irq_post_reset", 64'({TX, irq}), 64'({1'b1, 1'b0}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_mm_fifo.md
# uart_mm_fifo

Parametrised memory-mapped UART peripheral for the SoC data bus (port B). It contains an 8N1 transmitter and receiver with a runtime-programmable baud divisor and a TX FIFO and RX FIFO of configurable depth. It also provides sticky error flags and a level interrupt output. It sits on the same `addr_b`/`data_b` bus as the RAM and LED blocks and answers only inside its four-word window.

## Interface
- BASE, 65537: word address of register 0; the window is BASE..BASE+3.
- DEPTH_LOG2, 4: each FIFO holds 2^DEPTH_LOG2 bytes.
- DEFAULT_DIV, 868: reset value of the divisor (clocks per bit).
- clk  in  1  system clock; all logic runs on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- RX  in  1  serial input; asynchronous to clk.
- TX  out  1  serial output; idles high.
- addr_b  in  32  bus word address.
- data_b_in  in  32  bus write data.
- data_b_we  in  32  write enable; a write occurs when bit 0 is 1.
- data_b  out  32  read data, registered.
- strobe_b  out  1  high when data_b carries a valid response for this block.
- irq  out  1  level interrupt, registered.

## Operation
- Registers (offset from BASE):
  - DATA (+0), write: pushes data_b_in[7:0] into the TX FIFO.
    - If the TX FIFO is full, the byte is dropped and TXDROP is set.
  - DATA (+0), read: pops the RX FIFO and returns {24'b0, byte}.
    - If the RX FIFO is empty, it returns 0 and nothing is popped.
  - STATUS (+1), read bit map:
    - bit0 RXNE: RX FIFO not empty.
    - bit1 TXNF: TX FIFO not full.
    - bit2 TXIDLE: TX FIFO empty and shifter idle.
    - bit3 OVR, bit4 FERR, bit5 TXDROP: sticky error flags.
    - [15:8] RX count, [23:16] TX count; other bits 0.
  - STATUS (+1), write: a 1 in bits 3/4/5 clears the matching sticky flag.
  - DIV (+2): 16-bit divisor, read/write. Written values below 4 are stored as 4.
  - IEN (+3): bit0 enables the RX-not-empty interrupt; bit1 enables the TX-FIFO-empty interrupt.
- Read access definition:
  - A read access is a cycle with addr_b in the window, data_b_we[0]=0, and (previous addr_b differed or the previous cycle was a write).
  - The DATA pop happens only on that first cycle, so a held address never pops twice.
  - While the address is held, data_b keeps the popped value.
- Writes act in every cycle with data_b_we[0]=1 and the address in the window.
  - The bus master issues single-cycle write pulses.
- RX path:
  - Input passes through a 2-FF synchroniser.
  - States: IDLE, START, DATA, STOP.
  - A falling edge in IDLE enters START. At div/2 the line is sampled: high returns to IDLE (glitch), low enters DATA.
  - DATA samples 8 bits LSB first, every div clocks.
  - At the STOP sample point:
    - stop bit low: FERR set, byte discarded.
    - stop bit high and RX FIFO full: OVR set, byte dropped.
    - otherwise: byte pushed.
  - The state machine then returns to IDLE.
- TX path:
  - States: IDLE, START, DATA, STOP.
  - In IDLE with the TX FIFO non-empty, one byte is popped and START is entered.
  - Each bit lasts div clocks: start 0, 8 data bits LSB first, stop 1.
  - After STOP it returns to IDLE, or starts the next byte on the following cycle.
- Divisor handling: each state machine latches DIV at frame start. A DIV write mid-frame affects only later frames.
- FIFOs:
  - Circular buffers with pointer wrap at 2^DEPTH_LOG2 and a count of DEPTH_LOG2+1 bits.
  - Push and pop in the same cycle are both performed and the count is unchanged.
  - A push into a full FIFO is rejected even if a pop occurs in the same cycle.
- irq = (IEN0 & RXNE) | (IEN1 & TX FIFO empty), registered.

## Timing
- Reset values:
  - TX=1, data_b=0, strobe_b=0, irq=0.
  - FIFOs empty, flags 0, IEN=0, DIV=DEFAULT_DIV, both state machines IDLE.
- Reset mid-frame aborts the frame immediately; TX goes high asynchronously.
- Read latency:
  - Address in cycle N gives data_b and strobe_b=1 in cycle N+1.
  - strobe_b=0 in cycle N+1 for addresses outside the window or for write cycles.
- STATUS reflects state as of the end of cycle N: a pop or push in cycle N is visible at N+1.
- A write to DATA in cycle N is counted in STATUS from N+1. TX starts no earlier than N+2.
- RX to FIFO: the byte becomes visible in RXNE 1–2 cycles after the stop sample point, plus the 2-cycle synchroniser delay relative to the pin.
- Frame length: exactly 10×div clocks. Back-to-back TX frames have at most 1 idle clock between them.
- Simultaneous events:
  - An RX push and a bus pop in the same cycle are both honoured.
  - A STATUS clear write and a new error on the same cycle leave the flag set.

## Test plan
- Reset, then read BASE+1 -> strobe_b=1 next cycle; data_b=0x00000006 (TXNF, TXIDLE); read BASE+2 -> 868.
- DIV=4; write 0x55 to DATA -> TX shows 0,1,0,1,0,1,0,1,0,1, each held 4 clocks; 40 clocks total; then TXIDLE=1.
- DIV=4, DEPTH_LOG2=2; write 5 bytes in consecutive cycles -> 4 accepted, TXDROP=1. Write 0x20 to STATUS -> TXDROP=0.
- Loop TX to RX; send 0xA3 -> RXNE=1; DATA read held 3 cycles returns 0xA3 and pops once; next read returns 0 with RXNE=0.
- Drive RX frame 0x3C with stop bit low -> FERR=1, RX count 0. Fill RX with 4 bytes, send a 5th -> OVR=1, count stays 4.
- IEN=1 with RX empty -> irq=0. Receive a byte -> irq=1. Pop it -> irq=0 one cycle after the pop. Assert rst mid-TX-frame -> TX=1 immediately, FIFOs empty.
